// File: rtl/mmio_timer.sv
// mmio_timer: bus-mapped prescaled 32-bit timer with compare match and level irq.
// Ports: clk, rst (async active-low), addr/wdata/we bus in, rdata/hit/irq out.
module mmio_timer #(
    parameter logic [31:0] BASE    = 32'h0000_1000,
    parameter int unsigned PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] SEL_CTRL = 3'd0;
    localparam logic [2:0] SEL_PRES = 3'd1;
    localparam logic [2:0] SEL_CNT  = 3'd2;
    localparam logic [2:0] SEL_CMP  = 3'd3;
    localparam logic [2:0] SEL_STAT = 3'd4;

    localparam logic [PRESC_W-1:0] P_ONE = 1;

    logic [2:0]         r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic [31:0]        r_count;
    logic [31:0]        r_cmp;
    logic               r_match;

    logic [31:0] w_off;
    logic        w_hit;
    logic [2:0]  w_sel;
    logic        w_is_ctrl;
    logic        w_is_pres;
    logic        w_is_cnt;
    logic        w_is_cmp;
    logic        w_is_stat;
    logic        w_wr_ctrl;
    logic        w_wr_pres;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_stat;
    logic        w_pmatch;
    logic        w_tick;
    logic        w_cmp_eq;
    logic        w_set;
    logic [31:0] w_pres_ext;

    // Offset subtraction wraps for addr < BASE, so one compare covers both ends.
    assign w_off = addr - BASE;
    assign w_hit = (w_off < 32'h14) && (addr[1:0] == 2'b00);
    assign w_sel = w_off[4:2];

    assign w_is_ctrl = w_hit && (w_sel == SEL_CTRL);
    assign w_is_pres = w_hit && (w_sel == SEL_PRES);
    assign w_is_cnt  = w_hit && (w_sel == SEL_CNT);
    assign w_is_cmp  = w_hit && (w_sel == SEL_CMP);
    assign w_is_stat = w_hit && (w_sel == SEL_STAT);

    assign w_wr_ctrl = we && w_is_ctrl;
    assign w_wr_pres = we && w_is_pres;
    assign w_wr_cnt  = we && w_is_cnt;
    assign w_wr_cmp  = we && w_is_cmp;
    assign w_wr_stat = we && w_is_stat;

    // A PRESCALE write restarts the prescaler and suppresses this cycle's tick.
    assign w_pmatch = (r_pcnt == r_presc);
    assign w_tick   = r_ctrl[0] && w_pmatch && !w_wr_pres;
    assign w_cmp_eq = (r_count == r_cmp);
    // A COUNT write pre-empts both the increment and the match check.
    assign w_set    = w_tick && !w_wr_cnt && w_cmp_eq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_presc <= '0;
            r_pcnt  <= '0;
            r_count <= '0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
        end else begin
            if (w_wr_pres) begin
                r_presc <= wdata[PRESC_W-1:0];
                r_pcnt  <= '0;
            end else if (r_ctrl[0]) begin
                r_pcnt <= w_pmatch ? '0 : r_pcnt + P_ONE;
            end

            if (w_wr_cnt) begin
                r_count <= wdata;
            end else if (w_tick) begin
                if (!w_cmp_eq) begin
                    r_count <= r_count + 32'd1;
                end else if (r_ctrl[1]) begin
                    r_count <= '0;
                end
            end

            if (w_wr_cmp) begin
                r_cmp <= wdata;
            end

            // One-shot disables itself, but an explicit CTRL write wins.
            if (w_wr_ctrl) begin
                r_ctrl <= wdata[2:0];
            end else if (w_set && !r_ctrl[1]) begin
                r_ctrl[0] <= 1'b0;
            end

            // Hardware set beats a same-cycle write-1-to-clear.
            if (w_set) begin
                r_match <= 1'b1;
            end else if (w_wr_stat && wdata[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pres_ext = '0;
        w_pres_ext[PRESC_W-1:0] = r_presc;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            w_is_ctrl: rdata = {29'd0, r_ctrl};
            w_is_pres: rdata = w_pres_ext;
            w_is_cnt:  rdata = r_count;
            w_is_cmp:  rdata = r_cmp;
            w_is_stat: rdata = {31'd0, r_match};
            default:   rdata = '0;
        endcase
    end

    assign hit = w_hit;
    assign irq = r_match && r_ctrl[2];

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed bus stimulus with a queue-based scoreboard.
// Expectations are queued by stimulus and compared at the falling edge.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRES = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  localparam int K_RD  = 0;
  localparam int K_HIT = 1;
  localparam int K_IRQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t m_e;
  logic [31:0] m_act;

  mmio_timer #(
    .BASE    (BASE),
    .PRESC_W (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        K_HIT:   m_act = {31'd0, hit};
        K_IRQ:   m_act = {31'd0, irq};
        default: m_act = rdata;
      endcase
      n_chk++;
      if (m_act !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h",
                 m_e.name, m_act, m_e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int k,
                      input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    cyc();
    we    = 1'b0;
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] e,
                     input logic h, input string n);
    addr = a;
    we   = 1'b0;
    push(n, K_RD, e);
    push({n, "_hit"}, K_HIT, {31'd0, h});
    cyc();
  endtask

  task automatic pirq(input logic e, input string n);
    push(n, K_IRQ, {31'd0, e});
  endtask

  initial begin
    rst   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    addr = A_CMP;
    #1;
    n_chk++;
    if (rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL rst_cmp_direct: got %h", rdata);
    end

    chk(A_CNT, 32'd0, 1'b1, "rst_count");
    chk(A_CMP, 32'hFFFF_FFFF, 1'b1, "rst_compare");
    chk(A_CTRL, 32'd0, 1'b1, "rst_ctrl");
    chk(A_PRES, 32'd0, 1'b1, "rst_presc");
    pirq(1'b0, "rst_irq");
    chk(A_STAT, 32'd0, 1'b1, "rst_status");
    chk(32'h0, 32'd0, 1'b0, "addr0");

    wr(A_PRES, 32'd3);
    chk(A_PRES, 32'd3, 1'b1, "presc_rb");
    wr(A_CTRL, 32'd1);
    repeat (40) cyc();
    chk(A_CNT, 32'd10, 1'b1, "presc_count");
    wr(A_CTRL, 32'd0);

    wr(A_PRES, 32'd0);
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'd5);
    repeat (8) cyc();
    chk(A_CNT, 32'd5, 1'b1, "os_count");
    chk(A_STAT, 32'd1, 1'b1, "os_match");
    pirq(1'b1, "os_irq");
    chk(A_CTRL, 32'd4, 1'b1, "os_ctrl");
    wr(A_STAT, 32'd1);
    pirq(1'b0, "os_irq_clr");
    chk(A_STAT, 32'd0, 1'b1, "os_status_clr");

    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'd3);
    pirq(1'b0, "ar_irq0");
    chk(A_CNT, 32'd0, 1'b1, "ar_c0");
    pirq(1'b0, "ar_irq1");
    chk(A_CNT, 32'd1, 1'b1, "ar_c1");
    pirq(1'b0, "ar_irq2");
    chk(A_CNT, 32'd2, 1'b1, "ar_c2");
    pirq(1'b0, "ar_irq3");
    chk(A_STAT, 32'd1, 1'b1, "ar_match");
    pirq(1'b0, "ar_irq4");
    chk(A_CNT, 32'd1, 1'b1, "ar_c1b");
    chk(A_CNT, 32'd2, 1'b1, "ar_c2b");
    chk(A_CNT, 32'd0, 1'b1, "ar_c0b");
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);

    wr(A_CMP, 32'd1000);
    wr(A_CTRL, 32'd1);
    cyc();
    cyc();
    wr(A_CNT, 32'd100);
    chk(A_CNT, 32'd100, 1'b1, "coll_count");
    wr(A_CTRL, 32'd0);

    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd1);
    repeat (3) cyc();
    wr(A_STAT, 32'd1);
    chk(A_STAT, 32'd1, 1'b1, "coll_match");
    chk(A_CNT, 32'd3, 1'b1, "coll_os_count");
    chk(A_CTRL, 32'd0, 1'b1, "coll_os_ctrl");
    wr(A_STAT, 32'd1);

    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    wr(BASE + 32'h02, 32'd7);
    wr(BASE - 32'h04, 32'd7);
    chk(BASE + 32'h14, 32'd0, 1'b0, "dec_14");
    chk(BASE + 32'h02, 32'd0, 1'b0, "dec_02");
    chk(BASE - 32'h04, 32'd0, 1'b0, "dec_m4");
    chk(BASE + 32'h12, 32'd0, 1'b0, "dec_12");
    chk(A_CTRL, 32'd0, 1'b1, "dec_ctrl");
    chk(A_CNT, 32'd3, 1'b1, "dec_count");
    chk(A_CMP, 32'd3, 1'b1, "dec_cmp");
    chk(A_STAT, 32'd0, 1'b1, "dec_stat");

    wr(A_CMP, 32'd0);
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'd3);
    chk(A_CNT, 32'hFFFF_FFFF, 1'b1, "wrap_pre");
    chk(A_STAT, 32'd0, 1'b1, "wrap_noflag");
    chk(A_STAT, 32'd1, 1'b1, "wrap_match");
    chk(A_CNT, 32'd0, 1'b1, "wrap_count");

    wr(A_CTRL, 32'd0);
    wr(A_CMP, 32'd1000);
    wr(A_CNT, 32'd50);
    wr(A_STAT, 32'd1);
    wr(A_CTRL, 32'd7);
    cyc();
    cyc();
    addr = A_CNT;
    #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_direct_count: got %h", rdata);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_direct_irq: got %b", irq);
    end
    n_chk++;
    if (hit !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_direct_hit: got %b", hit);
    end
    pirq(1'b0, "arst_irq");
    push("arst_count", K_RD, 32'd0);
    cyc();
    chk(A_CMP, 32'hFFFF_FFFF, 1'b1, "arst_cmp");
    rst = 1'b1;
    repeat (3) cyc();
    chk(A_CNT, 32'd0, 1'b1, "post_rst_count");
    chk(A_CTRL, 32'd0, 1'b1, "post_rst_ctrl");

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    if (n_fail != 0) begin
      $fatal(1);
    end
    $finish;
  end

endmodule
